// File: rtl/clarvi_fetch_pkg.sv
// Shared types for the CLARVI instruction-fetch stage.
package clarvi_fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_RESP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fault;
        logic        valid;
    } fetch_buf_t;

endpackage

// File: rtl/clarvi_fetch.sv
// Instruction fetch: owns the fetch PC, one outstanding Avalon read, one-entry buffer to decode.
// Latency: read accepted -> data_valid -> instruction presented the following cycle.
// Backpressure: a new read issues only when the buffer is empty or being consumed; waitrequest holds the request.
module clarvi_fetch
    import clarvi_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          ADDR_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] instr_address,
    output logic                  instr_read_enable,
    input  logic                  instr_wait,
    input  logic [31:0]           instr_read_data,
    input  logic                  instr_read_data_valid,
    input  logic                  stall_stage,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    output logic [31:0]           if_de_instr,
    output logic [63:0]           if_de_pc,
    output logic                  if_de_invalid,
    output logic                  if_de_fault
);

    fetch_state_t state, state_nxt;
    logic [63:0]  fetch_pc, fetch_pc_nxt;
    logic [63:0]  req_pc, req_pc_nxt;
    logic         discard, discard_nxt;
    fetch_buf_t   ibuf, ibuf_nxt;

    logic consume;
    logic idle_go;
    logic aligned;

    always_comb begin
        consume = ibuf.valid && !stall_stage;
        aligned = (fetch_pc[1:0] == 2'b00);
        // Gating with reset_n keeps the request low while the stage is held in reset.
        idle_go = (state == F_IDLE) && (!ibuf.valid || consume) && !redirect_valid && reset_n;
        instr_read_enable = (state == F_REQ) || (idle_go && aligned);
        // While waiting for acceptance the address must not follow a redirect.
        instr_address = (state == F_REQ) ? req_pc[ADDR_WIDTH+1:2] : fetch_pc[ADDR_WIDTH+1:2];
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        discard_nxt  = discard;
        ibuf_nxt     = ibuf;
        if (consume) ibuf_nxt.valid = 1'b0;

        case (state)
            F_IDLE: begin
                if (idle_go) begin
                    if (aligned) begin
                        req_pc_nxt = fetch_pc;
                        if (!instr_wait) begin
                            state_nxt    = F_RESP;
                            fetch_pc_nxt = fetch_pc + 64'd4;
                        end else begin
                            state_nxt = F_REQ;
                        end
                    end else begin
                        ibuf_nxt = '{instr: NOP_INSTR, pc: fetch_pc, fault: 1'b1, valid: 1'b1};
                    end
                end
            end
            F_REQ: begin
                if (!instr_wait) begin
                    state_nxt = F_RESP;
                    // A pending discard means fetch_pc already holds a redirect target.
                    if (!discard) fetch_pc_nxt = fetch_pc + 64'd4;
                end
            end
            F_RESP: begin
                if (instr_read_data_valid) begin
                    state_nxt = F_IDLE;
                    if (discard) discard_nxt = 1'b0;
                    else ibuf_nxt = '{instr: instr_read_data, pc: req_pc, fault: 1'b0, valid: 1'b1};
                end
            end
            default: state_nxt = F_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt   = redirect_pc;
            ibuf_nxt.valid = 1'b0;
            if (state == F_REQ || (state == F_RESP && !instr_read_data_valid))
                discard_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_VECTOR;
            req_pc   <= '0;
            discard  <= 1'b0;
            ibuf     <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            discard  <= discard_nxt;
            ibuf     <= ibuf_nxt;
        end
    end

    assign if_de_instr   = ibuf.instr;
    assign if_de_pc      = ibuf.pc;
    assign if_de_fault   = ibuf.fault;
    assign if_de_invalid = !ibuf.valid;

endmodule

// File: tb/tb_clarvi_fetch.sv
// Bench for clarvi_fetch: directed vector table, corner sequences and a randomized run against a PC-sequence model.
module tb_clarvi_fetch;
    import clarvi_fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr_address;
    logic        instr_read_enable;
    logic        instr_wait = 1'b0;
    logic [31:0] instr_read_data = '0;
    logic        instr_read_data_valid = 1'b0;
    logic        stall_stage = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [31:0] if_de_instr;
    logic [63:0] if_de_pc;
    logic        if_de_invalid;
    logic        if_de_fault;

    always #5 clock = ~clock;

    clarvi_fetch #(.RESET_VECTOR(64'h1000), .ADDR_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_address(instr_address), .instr_read_enable(instr_read_enable),
        .instr_wait(instr_wait), .instr_read_data(instr_read_data),
        .instr_read_data_valid(instr_read_data_valid), .stall_stage(stall_stage),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_de_instr(if_de_instr), .if_de_pc(if_de_pc),
        .if_de_invalid(if_de_invalid), .if_de_fault(if_de_fault)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // memory model: one pending response, fixed latency per accepted read
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;
    int          mem_lat = 1;

    logic        s_re, s_inv, s_fault, s_acc;
    logic [15:0] s_addr;
    logic [63:0] s_pc;
    logic [31:0] s_instr;

    // One cycle: drive at negedge, sample 1ns later, advance to the next negedge.
    task automatic step(input logic st, input logic rv, input logic [63:0] rpc, input logic wt, input logic junk);
        stall_stage = st;
        redirect_valid = rv;
        redirect_pc = rpc;
        instr_wait = wt;
        instr_read_data_valid = 1'b0;
        instr_read_data = '0;
        if (pend) begin
            if (pend_cnt == 0) begin
                instr_read_data_valid = 1'b1;
                instr_read_data = memf(pend_addr);
                pend = 0;
            end else pend_cnt--;
        end else if (junk) begin
            instr_read_data_valid = 1'b1;
            instr_read_data = 32'hDEADBEEF;
        end
        #1;
        s_re = instr_read_enable; s_addr = instr_address; s_inv = if_de_invalid;
        s_fault = if_de_fault; s_pc = if_de_pc; s_instr = if_de_instr;
        s_acc = s_re && !wt;
        if (s_acc) begin
            chk("one_outstanding", pend, 0);
            pend = 1;
            pend_cnt = mem_lat - 1;
            pend_addr = s_addr;
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic        st;
        logic        rv;
        logic [63:0] rpc;
        logic        e_re;
        logic [15:0] e_addr;
        logic        e_inv;
        logic [63:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    task automatic redirect_case(input int k, input string name);
        int n;
        bit seen;
        mem_lat = 3;
        n = 0;
        s_acc = 0;
        while (!s_acc && n < 20) begin step(0, 0, 0, 0, 0); n++; end
        chk({name, "_accept"}, s_acc, 1);
        for (int j = 1; j < k; j++) step(0, 0, 0, 0, 0);
        step(0, 1, 64'h2000, 0, 0);
        step(0, 0, 0, 0, 0);
        if (k == 3) begin
            chk({name, "_issue_re"}, s_re, 1);
            chk({name, "_issue_addr"}, s_addr, 16'h0800);
        end
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            if (!s_inv) seen = 1;
            else step(0, 0, 0, 0, 0);
        end
        chk({name, "_presented"}, seen, 1);
        chk({name, "_pc"}, s_pc, 64'h2000);
        chk({name, "_instr"}, s_instr, memf(16'h0800));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pcs[$];
        logic [63:0] exp_pc;
        int consumed;
        int n;
        logic p_hold, p_wait;
        logic [63:0] p_pc;
        logic [31:0] p_instr;
        logic [15:0] p_addr;

        // reset state
        @(negedge clock);
        chk("rst_invalid", if_de_invalid, 1);
        chk("rst_fault", if_de_fault, 0);
        chk("rst_instr", if_de_instr, 0);
        chk("rst_pc", if_de_pc, 0);
        chk("rst_re", instr_read_enable, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // st rv rpc re addr inv pc fault
        tbl.push_back('{0, 0, 64'h0,    1, 16'h0400, 1, 64'h0,    0});
        tbl.push_back('{0, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{0, 0, 64'h0,    1, 16'h0401, 0, 64'h1000, 0});
        tbl.push_back('{0, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{0, 0, 64'h0,    1, 16'h0402, 0, 64'h1004, 0});
        tbl.push_back('{0, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h1008, 0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h1008, 0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h1008, 0});
        tbl.push_back('{0, 0, 64'h0,    1, 16'h0403, 0, 64'h1008, 0});
        tbl.push_back('{0, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h100C, 0});
        tbl.push_back('{1, 1, 64'h2002, 0, 16'h0,    0, 64'h100C, 0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h2002, 1});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h2002, 1});
        tbl.push_back('{1, 1, 64'h3000, 0, 16'h0,    0, 64'h2002, 1});
        tbl.push_back('{0, 0, 64'h0,    1, 16'h0C00, 1, 64'h0,    0});
        tbl.push_back('{0, 0, 64'h0,    0, 16'h0,    1, 64'h0,    0});
        tbl.push_back('{1, 0, 64'h0,    0, 16'h0,    0, 64'h3000, 0});

        mem_lat = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].rv, tbl[i].rpc, 0, 0);
            chk($sformatf("v%0d_re", i), s_re, tbl[i].e_re);
            if (tbl[i].e_re) chk($sformatf("v%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_invalid", i), s_inv, tbl[i].e_inv);
            if (!tbl[i].e_inv) begin
                chk($sformatf("v%0d_pc", i), s_pc, tbl[i].e_pc);
                chk($sformatf("v%0d_fault", i), s_fault, tbl[i].e_fault);
                chk($sformatf("v%0d_instr", i), s_instr,
                    tbl[i].e_fault ? NOP_INSTR : memf(tbl[i].e_pc[17:2]));
            end
        end

        // waitrequest held for 5 cycles
        for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("wait%0d_re", j), s_re, 1);
            chk($sformatf("wait%0d_addr", j), s_addr, 16'h0C01);
        end
        step(0, 0, 0, 0, 0);
        chk("wait_accept", s_acc, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wait_next_pc", s_pc, 64'h3004);
        chk("wait_next_addr", s_addr, 16'h0C02);

        redirect_case(1, "redir_resp");
        redirect_case(3, "redir_dv");

        // 64-bit PC wrap
        mem_lat = 1;
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
        pcs.delete();
        for (int j = 0; j < 40 && pcs.size() < 3; j++) begin
            step(0, 0, 0, 0, 0);
            if (!s_inv) begin
                pcs.push_back(s_pc);
                chk("wrap_instr", s_instr, memf(s_pc[17:2]));
            end
        end
        chk("wrap_count", pcs.size(), 3);
        if (pcs.size() == 3) begin
            chk("wrap_pc0", pcs[0], 64'hFFFF_FFFF_FFFF_FFF8);
            chk("wrap_pc1", pcs[1], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_pc2", pcs[2], 64'h0);
        end

        // reset in the middle of a transfer, then a stale data_valid in F_IDLE
        mem_lat = 3;
        n = 0;
        s_acc = 0;
        while (!s_acc && n < 20) begin step(0, 0, 0, 0, 0); n++; end
        chk("mid_accept", s_acc, 1);
        #2 reset_n = 1'b0;
        pend = 0;
        #1;
        chk("mid_rst_invalid", if_de_invalid, 1);
        chk("mid_rst_re", instr_read_enable, 0);
        chk("mid_rst_pc", if_de_pc, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mem_lat = 1;
        step(1, 0, 0, 0, 1);
        chk("mid_c0_re", s_re, 1);
        chk("mid_c0_addr", s_addr, 16'h0400);
        n = 0;
        while (s_inv && n < 20) begin step(1, 0, 0, 0, 0); n++; end
        chk("mid_first_pc", s_pc, 64'h1000);
        chk("mid_first_instr", s_instr, memf(16'h0400));

        // randomized run against the in-order PC sequence model
        exp_pc = 64'h0000_0000_0040_0000;
        step(1, 1, exp_pc, 0, 0);
        consumed = 0;
        p_hold = 0;
        p_wait = 0;
        p_pc = '0;
        p_instr = '0;
        p_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            logic st, rv, wt;
            logic [63:0] rpc;
            st = ($urandom_range(0, 9) < 4);
            rv = ($urandom_range(0, 99) < 3);
            wt = ($urandom_range(0, 9) < 3);
            rpc = {$urandom, $urandom} & ~64'h3;
            mem_lat = $urandom_range(1, 3);
            step(st, rv, rpc, wt, 0);
            if (p_hold) begin
                chk("rnd_hold_valid", s_inv, 0);
                chk("rnd_hold_pc", s_pc, p_pc);
                chk("rnd_hold_instr", s_instr, p_instr);
            end
            if (p_wait) begin
                chk("rnd_wait_re", s_re, 1);
                chk("rnd_wait_addr", s_addr, p_addr);
            end
            if (!s_inv && !st) begin
                chk("rnd_pc", s_pc, exp_pc);
                chk("rnd_instr", s_instr, memf(exp_pc[17:2]));
                chk("rnd_fault", s_fault, 0);
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            if (rv) exp_pc = rpc;
            p_hold = !s_inv && st && !rv;
            p_wait = s_re && wt;
            p_pc = s_pc;
            p_instr = s_instr;
            p_addr = s_addr;
        end
        chk("rnd_progress", (consumed > 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
